// File: rtl/param_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_stream_fifo
// Desc     : First-word-fall-through FIFO between a valid/ready producer and
//            a valid/ready consumer, with occupancy and almost-full reporting.
// Revision : 1.0 - initial release
// ============================================================================
module param_stream_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_full     = CW'(DEPTH);
  localparam logic [CW-1:0] c_afull    = CW'(AFULL_LVL);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;

  // Status is forced inactive while reset is held so nothing can handshake.
  assign in_ready    = rst_n & (r_count != c_full);
  assign out_valid   = rst_n & (r_count != '0);
  assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
  assign almost_full = rst_n & (r_count >= c_afull);
  assign count       = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Explicit compare-based wrap keeps non-power-of-two depths correct.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_stream_fifo.sv
`default_nettype none
// Bench for param_stream_fifo: directed and random traffic on a 16x5 instance
// plus named/positional overrides, all against queue-based reference models.
module tb_param_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst_n;
  logic [15:0] a_din;
  logic        a_iv, a_or, a_ir, a_ov, a_af;
  logic [15:0] a_dout;
  logic [2:0]  a_cnt;

  logic [31:0] b_din;
  logic        b_iv, b_or, b_ir, b_ov, b_af;
  logic [31:0] b_dout;
  logic [6:0]  b_cnt;

  logic        c_ir, c_ov, c_af;
  logic [15:0] c_dout;
  logic [5:0]  c_cnt;

  logic [15:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] qc[$];
  bit          a_pushed;
  bit          b_pushed;

  param_stream_fifo #(.WIDTH(16), .DEPTH(5)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_din), .in_valid(a_iv), .in_ready(a_ir),
    .out_data(a_dout), .out_valid(a_ov), .out_ready(a_or),
    .count(a_cnt), .almost_full(a_af)
  );

  param_stream_fifo #(.WIDTH(32), .DEPTH(64)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_din), .in_valid(b_iv), .in_ready(b_ir),
    .out_data(b_dout), .out_valid(b_ov), .out_ready(b_or),
    .count(b_cnt), .almost_full(b_af)
  );

  param_stream_fifo #(16, 32) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_din[15:0]), .in_valid(b_iv), .in_ready(c_ir),
    .out_data(c_dout), .out_valid(c_ov), .out_ready(b_or),
    .count(c_cnt), .almost_full(c_af)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output of every instance against its queue model.
  task automatic check_all();
    logic [63:0] ha, hb, hc;
    ha = (rst_n && qa.size() > 0) ? 64'(qa[0]) : 64'd0;
    hb = (rst_n && qb.size() > 0) ? 64'(qb[0]) : 64'd0;
    hc = (rst_n && qc.size() > 0) ? 64'(qc[0]) : 64'd0;
    chk("a_in_ready",    64'(a_ir),   64'(rst_n && qa.size() != 5));
    chk("a_out_valid",   64'(a_ov),   64'(rst_n && qa.size() != 0));
    chk("a_out_data",    64'(a_dout), ha);
    chk("a_count",       64'(a_cnt),  64'(qa.size()));
    chk("a_almost_full", 64'(a_af),   64'(rst_n && qa.size() >= 3));
    chk("b_in_ready",    64'(b_ir),   64'(rst_n && qb.size() != 64));
    chk("b_out_valid",   64'(b_ov),   64'(rst_n && qb.size() != 0));
    chk("b_out_data",    64'(b_dout), hb);
    chk("b_count",       64'(b_cnt),  64'(qb.size()));
    chk("b_almost_full", 64'(b_af),   64'(rst_n && qb.size() >= 62));
    chk("c_in_ready",    64'(c_ir),   64'(rst_n && qc.size() != 32));
    chk("c_out_valid",   64'(c_ov),   64'(rst_n && qc.size() != 0));
    chk("c_out_data",    64'(c_dout), hc);
    chk("c_count",       64'(c_cnt),  64'(qc.size()));
    chk("c_almost_full", 64'(c_af),   64'(rst_n && qc.size() >= 30));
  endtask

  // Reference behaviour at a rising edge, from the pre-edge occupancy.
  task automatic model_step();
    bit pa, oa, pb, ob, pc, oc;
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete();
      a_pushed = 1'b0; b_pushed = 1'b0;
    end else begin
      pa = a_iv && qa.size() < 5;  oa = a_or && qa.size() > 0;
      pb = b_iv && qb.size() < 64; ob = b_or && qb.size() > 0;
      pc = b_iv && qc.size() < 32; oc = b_or && qc.size() > 0;
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back(a_din);
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back(b_din);
      if (oc) void'(qc.pop_front());
      if (pc) qc.push_back(b_din[15:0]);
      a_pushed = pa; b_pushed = pb;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    a_din = '0; a_iv = 1'b0; a_or = 1'b0;
    b_din = '0; b_iv = 1'b0; b_or = 1'b0;

    // Reset held for three edges, then released.
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("rel_count", 64'(a_cnt), 64'd0);
    chk("rel_in_ready", 64'(a_ir), 64'd1);

    // Latency and order.
    a_din = 16'h1234; a_iv = 1'b1;
    cycle();
    chk("lat_data", 64'(a_dout), 64'h1234);
    chk("lat_count", 64'(a_cnt), 64'd1);
    a_din = 16'h5678;
    cycle();
    a_iv = 1'b0; a_or = 1'b1;
    cycle();
    chk("order_second", 64'(a_dout), 64'h5678);
    cycle();
    chk("order_empty", 64'(a_cnt), 64'd0);

    // Fill to full; the sixth word must be held off.
    a_or = 1'b0; a_iv = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_din = 16'(i);
      cycle();
    end
    chk("full_in_ready", 64'(a_ir), 64'd0);
    a_din = 16'h0006;
    repeat (2) cycle();
    chk("full_held_count", 64'(a_cnt), 64'd5);
    a_or = 1'b1;
    cycle();
    a_or = 1'b0;
    chk("full_freed", 64'(a_ir), 64'd1);
    cycle();
    chk("full_refill", 64'(a_cnt), 64'd5);
    a_iv = 1'b0; a_or = 1'b1;
    repeat (6) cycle();

    // Steady push+pop at count=2 across several pointer wraps.
    a_or = 1'b0; a_iv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_din = 16'h0100 + 16'(i);
      cycle();
    end
    a_or = 1'b1;
    for (int i = 2; i < 14; i++) begin
      a_din = 16'h0100 + 16'(i);
      cycle();
      chk("wrap_count", 64'(a_cnt), 64'd2);
      chk("wrap_head", 64'(a_dout), 64'h0100 + 64'(i - 1));
    end

    // Random traffic honouring the producer hold rule.
    for (int i = 0; i < 300; i++) begin
      if (!a_iv || a_pushed) begin
        a_iv  = 1'($urandom_range(0, 1));
        a_din = 16'($urandom);
      end
      a_or = 1'($urandom_range(0, 2) != 0);
      if (i < 100) a_or = 1'($urandom_range(0, 3) == 0);
      cycle();
    end

    // Mid-stream reset with count=4 and both handshakes requested.
    a_iv = 1'b0; a_or = 1'b1;
    repeat (6) cycle();
    a_or = 1'b0; a_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_din = 16'hA000 + 16'(i);
      cycle();
    end
    chk("pre_reset_count", 64'(a_cnt), 64'd4);
    rst_n = 1'b0; a_or = 1'b1; a_din = 16'hBEEF;
    #1;
    check_all();
    cycle();
    chk("mid_reset_count", 64'(a_cnt), 64'd0);
    chk("mid_reset_valid", 64'(a_ov), 64'd0);
    rst_n = 1'b1; a_iv = 1'b0; a_or = 1'b0;
    cycle();
    chk("post_reset_count", 64'(a_cnt), 64'd0);
    chk("post_reset_valid", 64'(a_ov), 64'd0);

    // Named and positional overrides fed the same stream.
    b_din = 32'h5678; b_iv = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (b_pushed) b_din = b_din + 32'd1;
    end
    chk("b_full_count", 64'(b_cnt), 64'd64);
    chk("b_full_ready", 64'(b_ir), 64'd0);
    chk("c_full_count", 64'(c_cnt), 64'd32);
    chk("c_full_ready", 64'(c_ir), 64'd0);
    b_iv = 1'b0; b_or = 1'b1;
    repeat (66) cycle();
    chk("b_drained", 64'(b_cnt), 64'd0);
    chk("c_drained", 64'(c_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_stream_fifo.md
Name: param_stream_fifo

Overview:
- Parameterized synchronous first-word-fall-through FIFO.
- It is the storage stage that feeds a downstream WIDTH-bit consumer holding a DEPTH-entry memory array.
- WIDTH and DEPTH are overridable at instantiation, both positionally (#(16, 5)) and by name (#(.WIDTH(16), .DEPTH(5))).
- It decouples a valid/ready producer from the consumer and reports occupancy.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2). Need not be a power of two.
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  WIDTH  head-of-queue word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes the head word this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_LVL.

Behaviour:
- Storage and pointers:
  - Storage is mem[0:DEPTH-1] of WIDTH bits.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide (minimum 1).
  - Each pointer wraps from DEPTH-1 to 0 explicitly by compare, not by natural overflow, so non-power-of-two DEPTH works.
- Reset (rst_n low at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Memory contents are not cleared.
  - While rst_n is low: in_ready=0, out_valid=0, out_data=0, almost_full=0.
- Combinational outputs once out of reset:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - almost_full = (count >= AFULL_LVL).
- Push and pop:
  - push = in_valid & in_ready. It writes mem[wr_ptr] <= in_data and advances wr_ptr.
  - pop = out_valid & out_ready. It advances rd_ptr.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N (from cycle N+1). There is no same-cycle bypass when empty.
- Full:
  - in_ready=0, independent of out_ready. in_ready never depends combinationally on out_ready.
  - A pop while full frees one slot; in_ready rises the following cycle.
- Empty: out_valid=0. A push while empty cannot be popped in the same cycle.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance and count is unchanged.
- Ordering: strict FIFO order preserved across any number of pointer wraps.
- in_valid while in_ready=0: ignored and not stored. The producer must hold the word.
- Handshake protocol: the producer must not drop in_valid or change in_data until accepted. The FIFO never withdraws out_valid or changes out_data until a pop.
- Reset mid-operation: all contents are discarded, outputs take their reset values that cycle, and no partial push or pop occurs on the reset edge.

Test Plan:
- Reset: WIDTH=16, DEPTH=5. Hold rst_n=0 for 3 cycles, then release -> in_ready=0 and out_valid=0 during reset; count=0, in_ready=1, out_valid=0 after release.
- Latency and order:
  - Push 16'h1234 with out_ready=0 -> out_valid=1, out_data=16'h1234, count=1 on the next cycle.
  - Push 16'h5678, then pop twice -> 16'h1234 then 16'h5678, count returns to 0.
- Full (DEPTH=5, AFULL_LVL=3):
  - Push 0x0001..0x0005 -> almost_full rises at count=3; in_ready=0 at count=5.
  - A sixth word 0x0006 is held and not stored.
  - One pop -> in_ready=1 on the next cycle, then 0x0006 is accepted.
- Wrap and simultaneous push/pop:
  - With count=2, run in_valid=out_ready=1 for 12 cycles on incrementing data -> count stays 2, output sequence is gap-free and in order across 2+ pointer wraps.
- Named vs positional override, same stimulus to both:
  - #(.WIDTH(32), .DEPTH(64)) fed 32'h5678 ... -> 64 entries before in_ready=0; count is 7 bits and reads 64.
  - #(16, 32) -> 32 entries, count reads 32 when full.
- Mid-stream reset: with count=4, assert rst_n=0 for 1 cycle while in_valid=1 and out_ready=1 -> count=0, no word accepted, out_valid=0 after the reset edge.
